mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory/GPIO arbiter: FSM states, bus owner ids and
// the default GPIO address tag.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam logic [3:0] GPIO_TAG_DEFAULT = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a program-loader port onto one synchronous memory
// plus a memory-mapped GPIO output register; one access every three cycles.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [3:0]  GPIO_TAG = GPIO_TAG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    input  logic              boot,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] gpio_out,
    output logic              busy
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q, last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cap_we_q, cap_we_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   gpio_out_q, gpio_out_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ldr_ack_q, ldr_ack_d;

    logic [1:0]          req_vec;
    logic [1:0]          gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_gpio;
    logic                cap_gpio;
    logic [DATA_W-1:0]   resp_data;

    // CPU is ineligible during boot; loader always is.
    assign req_vec = {ldr_req, cpu_req & ~boot};

    rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (logic'(last_q)),
        .gnt  (gnt)
    );

    assign sel_addr  = gnt[1] ? ldr_addr  : cpu_addr;
    assign sel_wdata = gnt[1] ? ldr_wdata : cpu_wdata;
    assign sel_we    = gnt[1] ? ldr_we    : cpu_we;
    assign sel_gpio  = (sel_addr[ADDR_W-1 -: 4] == GPIO_TAG);
    assign cap_gpio  = (mem_addr_q[ADDR_W-1 -: 4] == GPIO_TAG);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cap_we_d    = cap_we_q;
        mem_we_d    = 1'b0;
        gpio_out_d  = gpio_out_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    state_d     = ST_ACCESS;
                    owner_d     = gnt[1] ? OWN_LDR : OWN_CPU;
                    last_d      = owner_d;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    cap_we_d    = sel_we;
                    mem_we_d    = sel_we & ~sel_gpio;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (cap_gpio && cap_we_q) begin
                    gpio_out_d = mem_wdata_q;
                end
                cpu_ack_d = (owner_q == OWN_CPU);
                ldr_ack_d = (owner_q == OWN_LDR);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Last grant resets to the loader so the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_LDR;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cap_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            gpio_out_q  <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cap_we_q    <= cap_we_d;
            mem_we_q    <= mem_we_d;
            gpio_out_q  <= gpio_out_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
        end
    end

    // Memory read data only arrives in RESP, so read data is steered, not stored.
    assign resp_data = cap_we_q ? '0 : (cap_gpio ? gpio_out_q : mem_rdata);

    assign cpu_rdata = cpu_ack_q ? resp_data : '0;
    assign ldr_rdata = ldr_ack_q ? resp_data : '0;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign gpio_out  = gpio_out_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small one-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, boot;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata, gpio_out;
    logic        cpu_ack, cpu_stall, ldr_ack, mem_we, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem [16];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack), .boot(boot),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .gpio_out(gpio_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Word memory: contents reload while reset is low; word 4 (addr 0x10) = DEADBEEF.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
            tb_mem[4] <= 32'hDEAD_BEEF;
        end else if (mem_we) begin
            tb_mem[mem_addr[5:2]] <= mem_wdata;
        end
        mem_rdata <= tb_mem[mem_addr[5:2]];
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; boot = 0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if ({cpu_ack, ldr_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {cpu_ack, ldr_ack}); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h expected 0", gpio_out); end
        checks++; if ((cpu_rdata | ldr_rdata) !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", cpu_rdata, ldr_rdata); end
        reset = 1'b1;
    endtask

    task automatic test_cpu_read;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c1: got %b expected 1", cpu_stall); end
        tick();
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rd_mem_addr_c2: got %h expected 00000010", mem_addr); end
        checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_stall_c2: got stall %b ack %b expected 1 0", cpu_stall, cpu_ack); end
        checks++; if (busy !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_busy_c2: got busy %b we %b expected 1 0", busy, mem_we); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c3: got %b expected 1", cpu_ack); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_c3: got %h expected deadbeef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0 || ldr_ack !== 1'b0) begin errors++; $display("FAIL rd_c3_misc: got stall %b ldr_ack %b expected 0 0", cpu_stall, ldr_ack); end
        cpu_req = 0;
        tick();
        checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_c4_idle: got ack %b busy %b expected 0 0", cpu_ack, busy); end
    endtask

    task automatic test_round_robin;
        int         n;
        logic [3:0] seq;
        logic       both;
        n = 0; seq = '0; both = 0;
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h8;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (cpu_ack && ldr_ack) both = 1;
            if (cpu_ack) begin
                checks++; if (cpu_rdata !== 32'h1000_0001) begin errors++; $display("FAIL rr_cpu_rdata: got %h expected 10000001", cpu_rdata); end
            end
            if (ldr_ack) begin
                checks++; if (ldr_rdata !== 32'h1000_0002) begin errors++; $display("FAIL rr_ldr_rdata: got %h expected 10000002", ldr_rdata); end
            end
            if (cpu_ack || ldr_ack) begin
                if (n < 4) seq[n] = ldr_ack;
                n++;
            end
        end
        cpu_req = 0; ldr_req = 0;
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks expected 4", n); end
        checks++; if (seq !== 4'b1010) begin errors++; $display("FAIL rr_order: got %b expected 1010 (C,L,C,L)", seq); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_double_ack: got %b expected 0", both); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_boot;
        int          pulses;
        logic [31:0] we_addr, we_data;
        logic        cpu_acked, stall_low, ldr_acked, got;
        pulses = 0; we_addr = 'x; we_data = 'x;
        cpu_acked = 0; stall_low = 0; ldr_acked = 0; got = 0;
        boot = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h0; ldr_wdata = 32'h20;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_we) begin pulses++; we_addr = mem_addr; we_data = mem_wdata; end
            if (cpu_ack) cpu_acked = 1;
            if (!cpu_stall) stall_low = 1;
            if (ldr_ack) begin ldr_acked = 1; ldr_req = 0; end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL boot_we_pulses: got %0d expected 1", pulses); end
        checks++; if (we_addr !== 32'h0 || we_data !== 32'h20) begin errors++; $display("FAIL boot_write: got %h<=%h expected 00000000<=00000020", we_addr, we_data); end
        checks++; if (cpu_acked !== 1'b0) begin errors++; $display("FAIL boot_cpu_ack: got %b expected 0", cpu_acked); end
        checks++; if (stall_low !== 1'b0) begin errors++; $display("FAIL boot_stall: stall dropped %b expected 0", stall_low); end
        checks++; if (ldr_acked !== 1'b1) begin errors++; $display("FAIL boot_ldr_ack: got %b expected 1", ldr_acked); end
        boot = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (cpu_ack) begin
                got = 1;
                checks++; if (cpu_rdata !== 32'h1000_000C) begin errors++; $display("FAIL boot_cpu_rdata: got %h expected 1000000c", cpu_rdata); end
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL boot_cpu_served: got %b expected 1", got); end
        cpu_req = 0;
        tick();
    endtask

    task automatic test_gpio;
        logic we_seen, got;
        we_seen = 0; got = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hF000_0000; cpu_wdata = 32'hA5;
        for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (mem_we) we_seen = 1;
            if (cpu_ack) begin
                got = 1;
                checks++; if (gpio_out !== 32'hA5) begin errors++; $display("FAIL gpio_out: got %h expected 000000a5", gpio_out); end
                checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL gpio_wr_rdata: got %h expected 0", cpu_rdata); end
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL gpio_wr_ack: got %b expected 1", got); end
        cpu_req = 0;
        tick();
        got = 0;
        cpu_req = 1; cpu_we = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (mem_we) we_seen = 1;
            if (cpu_ack) begin
                got = 1;
                checks++; if (cpu_rdata !== 32'hA5) begin errors++; $display("FAIL gpio_rd_data: got %h expected 000000a5", cpu_rdata); end
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL gpio_rd_ack: got %b expected 1", got); end
        checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL gpio_mem_we: got %b expected 0", we_seen); end
        cpu_req = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        logic acked, gpio_set;
        acked = 0; gpio_set = 0;
        pulse_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hF000_0000; cpu_wdata = 32'h5A;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access: got busy %b expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got busy %b we %b expected 0 0", busy, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid_mem: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        checks++; if (gpio_out !== 32'h0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_gpio_ack: got %h %b expected 0 0", gpio_out, cpu_ack); end
        cpu_req = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (cpu_ack || ldr_ack) acked = 1;
            if (gpio_out != 32'h0) gpio_set = 1;
        end
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ack: got %b expected 0", acked); end
        checks++; if (gpio_set !== 1'b0) begin errors++; $display("FAIL rst_mid_gpio_stays: got %b expected 0", gpio_set); end
    endtask

    task automatic test_ldr_drop;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h8;
        tick();
        ldr_req = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_access: got busy %b expected 1", busy); end
        tick();
        checks++; if (ldr_ack !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL drop_ack: got ldr %b cpu %b expected 1 0", ldr_ack, cpu_ack); end
        checks++; if (ldr_rdata !== 32'h1000_0002) begin errors++; $display("FAIL drop_rdata: got %h expected 10000002", ldr_rdata); end
        tick();
        checks++; if (ldr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got ack %b busy %b expected 0 0", ldr_ack, busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_boot();
        test_gpio();
        test_reset_mid();
        test_ldr_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
